// File: rtl/mdu_issue_queue.sv
`default_nettype none
// =============================================================================
// Module   : mdu_issue_queue
// Summary  : Request FIFO and one-at-a-time sequencer in front of MultDivUnit.
//            Accepts valid/ready requests, issues each with a one-cycle start
//            pulse, waits for the rising edge of done, and holds the result in
//            a valid/ready response register. Opcodes are never decoded.
// Options  : define MDU_TIMEOUT_EN to add the TIMEOUT parameter and the
//            rsp_timeout output (bounded wait for done).
// Revision : 1.0 - initial release
// =============================================================================
module mdu_issue_queue #(
    parameter int parallelism = 32,
    parameter int DEPTH       = 4
`ifdef MDU_TIMEOUT_EN
    ,
    parameter int TIMEOUT     = 256
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [2:0]                 req_opCode,
    input  logic [parallelism-1:0]     req_lOp,
    input  logic [parallelism-1:0]     req_rOp,
    output logic                       issue_valid,
    output logic [2:0]                 issue_opCode,
    output logic [parallelism-1:0]     issue_lOp,
    output logic [parallelism-1:0]     issue_rOp,
    input  logic                       unit_done,
    input  logic [parallelism-1:0]     unit_result,
    input  logic                       unit_divByZero,
    input  logic                       unit_divOverflow,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [parallelism-1:0]     rsp_result,
    output logic                       rsp_divByZero,
    output logic                       rsp_divOverflow,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy
`ifdef MDU_TIMEOUT_EN
    ,
    output logic                       rsp_timeout
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = 3 + 2 * parallelism;
`ifdef MDU_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                 state_q;

    // FIFO storage: {opCode, lOp, rOp} per entry
    logic [ENT_W-1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic [ENT_W-1:0]       head;
    logic                   push;
    logic                   pop;

    logic                   done_q;
    logic                   done_rise;

    logic                   issue_valid_q;
    logic [2:0]             issue_op_q;
    logic [parallelism-1:0] issue_l_q;
    logic [parallelism-1:0] issue_r_q;

    logic                   rsp_valid_q;
    logic [parallelism-1:0] rsp_result_q;
    logic                   rsp_dz_q;
    logic                   rsp_ov_q;
`ifdef MDU_TIMEOUT_EN
    logic                   rsp_to_q;
    logic [TMR_W-1:0]       timer_q;
`endif

    // No pass-through when full: a same-cycle pop does not open a slot.
    assign req_ready = (count_q < CNT_W'(DEPTH));
    assign push      = req_valid && req_ready;
    assign head      = mem_q[rd_ptr_q];

    // The head leaves the FIFO either from IDLE or straight out of RESP on
    // the response handshake, so the next issue follows without an idle gap.
    assign pop = (count_q != '0) &&
                 ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));

    // The unit may hold done for several cycles; only its rising edge counts.
    assign done_rise = unit_done && !done_q;

    // Occupancy next-state: simultaneous push and pop leave count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO payload write; storage contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_opCode, req_lOp, req_rOp};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Delayed copy of done for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= unit_done;
        end
    end

    // Issue registers: loaded on every pop, held until the next pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid_q <= 1'b0;
            issue_op_q    <= '0;
            issue_l_q     <= '0;
            issue_r_q     <= '0;
        end else begin
            issue_valid_q <= pop;
            if (pop) begin
                issue_op_q <= head[ENT_W-1 -: 3];
                issue_l_q  <= head[2*parallelism-1 -: parallelism];
                issue_r_q  <= head[parallelism-1:0];
            end
        end
    end

    // Sequencer FSM with registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_dz_q     <= 1'b0;
            rsp_ov_q     <= 1'b0;
`ifdef MDU_TIMEOUT_EN
            rsp_to_q     <= 1'b0;
            timer_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) state_q <= S_ISSUE;
                end
                // A done edge arriving during the issue cycle is honoured too.
                S_ISSUE, S_WAIT: begin
                    if (done_rise) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= unit_result;
                        rsp_dz_q     <= unit_divByZero;
                        rsp_ov_q     <= unit_divOverflow;
`ifdef MDU_TIMEOUT_EN
                        rsp_to_q     <= 1'b0;
`endif
                        state_q      <= S_RESP;
                    end
`ifdef MDU_TIMEOUT_EN
                    else if ((state_q == S_WAIT) &&
                             (timer_q == TMR_W'(TIMEOUT - 1))) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= '0;
                        rsp_dz_q     <= 1'b0;
                        rsp_ov_q     <= 1'b0;
                        rsp_to_q     <= 1'b1;
                        state_q      <= S_RESP;
                    end
`endif
                    else begin
                        state_q <= S_WAIT;
`ifdef MDU_TIMEOUT_EN
                        // Counter starts from zero on entry to WAIT.
                        timer_q <= (state_q == S_ISSUE) ? '0 : timer_q + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= pop ? S_ISSUE : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign issue_valid     = issue_valid_q;
    assign issue_opCode    = issue_op_q;
    assign issue_lOp       = issue_l_q;
    assign issue_rOp       = issue_r_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_result      = rsp_result_q;
    assign rsp_divByZero   = rsp_dz_q;
    assign rsp_divOverflow = rsp_ov_q;
    assign count           = count_q;
    assign busy            = (state_q != S_IDLE) || (count_q != '0);
`ifdef MDU_TIMEOUT_EN
    assign rsp_timeout     = rsp_to_q;
`endif

endmodule
`default_nettype wire
